// File: rtl/cpu_mem_pkg.sv
// Shared cpu/RAM definitions: arbiter FSM encodings, port indices and default widths.
package cpu_mem_pkg;

    localparam int RAM_WIDTH_DEF = 9;
    localparam int RAM_ADDR_DEF  = 11;

    localparam int PORT_CPU = 0;
    localparam int PORT_EXT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RD_CAP  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational 2-way picker: round-robin by default, cpu-first when
// RAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_sel,
    output logic       o_valid
);

    assign o_valid = |i_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = i_last;
    // cpu wins every contention; ext may starve
    assign o_sel = ~i_req[0];
`else
    // on a tie hand the grant to the port that did not win last time
    assign o_sel = (i_req == 2'b11) ? ~i_last : i_req[1];
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (port 0 cpu, port 1 ext).
// Round-robin on contention; RAM_ARB_FIXED_PRIO_EN selects fixed cpu priority.
//
// Handshake: a requester raises i_req[p] with i_we/i_addr/i_wdata stable and holds them
// until it sees o_gnt[p]; the fields are consumed in the grant cycle, and a request
// still held afterwards counts as a new one. Reads answer with o_rvalid[p] two cycles
// after the grant, o_rdata valid only alongside it.
module ram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int g_RAM_WIDTH = RAM_WIDTH_DEF,
    parameter int g_RAM_ADDR  = RAM_ADDR_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_req,
    input  logic [1:0]             i_we,
    input  logic [g_RAM_ADDR-1:0]  i_addr0,
    input  logic [g_RAM_ADDR-1:0]  i_addr1,
    input  logic [g_RAM_WIDTH-1:0] i_wdata0,
    input  logic [g_RAM_WIDTH-1:0] i_wdata1,
    output logic [1:0]             o_gnt,
    output logic [1:0]             o_rvalid,
    output logic [g_RAM_WIDTH-1:0] o_rdata,
    output logic                   o_busy,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [g_RAM_ADDR-1:0]  o_ram_addr,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [1:0]             o_dbg_state
);

    arb_state_t state, state_nxt;
    logic       r_sel, r_we, r_last;
    logic       pick_sel, pick_valid;

    logic                   req_we;
    logic [g_RAM_ADDR-1:0]  req_addr;
    logic [g_RAM_WIDTH-1:0] req_wdata;

    logic [1:0]             gnt_nxt, rvalid_nxt;
    logic                   ram_en_nxt, ram_we_nxt, busy_nxt;
    logic [g_RAM_ADDR-1:0]  ram_addr_nxt;
    logic [g_RAM_WIDTH-1:0] ram_data_nxt;

    rr_pick2 u_pick (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_sel   (pick_sel),
        .o_valid (pick_valid)
    );

    assign req_we    = i_we[pick_sel];
    assign req_addr  = pick_sel ? i_addr1  : i_addr0;
    assign req_wdata = pick_sel ? i_wdata1 : i_wdata0;

    assign o_dbg_state = state;

    // The RAM address/data output registers double as the request latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_last     <= 1'b1;
            o_gnt      <= '0;
            o_rvalid   <= '0;
            o_rdata    <= '0;
            o_busy     <= 1'b0;
            o_ram_en   <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_data <= '0;
        end else begin
            state      <= state_nxt;
            o_gnt      <= gnt_nxt;
            o_rvalid   <= rvalid_nxt;
            o_busy     <= busy_nxt;
            o_ram_en   <= ram_en_nxt;
            o_ram_we   <= ram_we_nxt;
            o_ram_addr <= ram_addr_nxt;
            o_ram_data <= ram_data_nxt;
            if (state == IDLE && pick_valid) begin
                r_sel  <= pick_sel;
                r_we   <= req_we;
                r_last <= pick_sel;
            end
            if (state == RD_WAIT) begin
                o_rdata <= i_ram_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = r_we ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Values the output registers take at the coming edge.
    always_comb begin
        gnt_nxt      = '0;
        rvalid_nxt   = '0;
        ram_en_nxt   = 1'b0;
        ram_we_nxt   = 1'b0;
        ram_addr_nxt = '0;
        ram_data_nxt = '0;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_nxt      = port_onehot(pick_sel);
                    ram_en_nxt   = 1'b1;
                    ram_we_nxt   = req_we;
                    ram_addr_nxt = req_addr;
                    ram_data_nxt = req_wdata;
                end
            end
            RD_WAIT: rvalid_nxt = port_onehot(r_sel);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table, contention/reset/pulse sequences, and a
// grant-ordered scoreboard fed by a monitor. Honours RAM_ARB_FIXED_PRIO_EN.
module tb_ram_port_arbiter;

    localparam int W = 9;
    localparam int A = 11;

    typedef struct packed {
        logic         port;
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic         port;
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic         we0 = 1'b0, we1 = 1'b0;
    logic [A-1:0] addr0 = '0, addr1 = '0;
    logic [W-1:0] wd0 = '0, wd1 = '0;
    logic [1:0]   gnt, rvalid, dbg_state;
    logic [W-1:0] rdata, ram_data_out, ram_q;
    logic         busy, ram_en, ram_we;
    logic [A-1:0] ram_addr;

    logic [W-1:0] mem [0:(1<<A)-1];

    exp_t exp_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   lat_a, lat_b;

    int           rd_cnt = 0;
    logic         rd_port;
    logic [W-1:0] rd_exp;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       ({req1, req0}),
        .i_we        ({we1, we0}),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wd0),
        .i_wdata1    (wd1),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_data  (ram_data_out),
        .i_ram_data  (ram_q),
        .o_dbg_state (dbg_state)
    );

    // Single-port synchronous RAM with one-cycle read latency.
    initial begin
        for (int i = 0; i < (1 << A); i++) mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_data_out;
            else        ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic p, input logic we, input logic [A-1:0] a,
                                     input logic [W-1:0] d);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Raise a request and hold it until the grant is seen; lat = negedges waited.
    task automatic do_req(input int p, input logic we, input logic [A-1:0] a,
                          input logic [W-1:0] d, output int lat);
        lat = 0;
        if (p == 0) begin we0 = we; addr0 = a; wd0 = d; req0 = 1'b1; end
        else        begin we1 = we; addr1 = a; wd1 = d; req1 = 1'b1; end
        do begin
            @(negedge clk);
            lat++;
        end while (!gnt[p] && lat < 40);
        if (!gnt[p]) begin
            errors++;
            $display("FAIL grant_timeout: port %0d got no grant within %0d cycles", p, lat);
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    // Monitor: protocol rules every cycle, grants against exp_q, reads at grant+2.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt = 0;
                continue;
            end
            checks++;
            if ((|gnt && |rvalid) || !$onehot0(gnt) || !$onehot0(rvalid) || (ram_en != |gnt)) begin
                errors++;
                $display("FAIL protocol: gnt=%b rvalid=%b ram_en=%b", gnt, rvalid, ram_en);
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    chk("rvalid_port", 32'(rvalid), 32'(onehot(rd_port)));
                    chk("rdata", 32'(rdata), 32'(rd_exp));
                end
            end else if (|rvalid) begin
                errors++;
                $display("FAIL unexpected_rvalid: got %b required 00", rvalid);
            end
            if (|gnt) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: got %b required 00", gnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_port", 32'(gnt), 32'(onehot(e.port)));
                    chk("ram_we", 32'(ram_we), 32'(e.we));
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    if (e.we) chk("ram_wdata", 32'(ram_data_out), 32'(e.data));
                    else begin
                        rd_cnt  = 2;
                        rd_port = e.port;
                        rd_exp  = e.data;
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 11'h005, 9'h1A5, 9'h000};
        vecs[1] = '{1'b0, 1'b0, 11'h005, 9'h000, 9'h1A5};
        vecs[2] = '{1'b1, 1'b1, 11'h123, 9'h055, 9'h000};
        vecs[3] = '{1'b1, 1'b0, 11'h123, 9'h000, 9'h055};
        vecs[4] = '{1'b1, 1'b1, 11'h7FF, 9'h1FF, 9'h000};
        vecs[5] = '{1'b0, 1'b0, 11'h7FF, 9'h000, 9'h1FF};
        vecs[6] = '{1'b0, 1'b1, 11'h000, 9'h0AA, 9'h000};
        vecs[7] = '{1'b1, 1'b0, 11'h000, 9'h000, 9'h0AA};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single-port vectors
        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i].port, vecs[i].we, vecs[i].addr,
                     vecs[i].we ? vecs[i].wdata : vecs[i].exp_rdata);
            do_req(int'(vecs[i].port), vecs[i].we, vecs[i].addr, vecs[i].wdata, lat_a);
            chk("gnt_latency", 32'(lat_a), 32'd1);
            chk("busy_at_gnt", 32'(busy), 32'd1);
            repeat (vecs[i].we ? 1 : 3) @(negedge clk);
            chk("idle_after_access", 32'(busy), 32'd0);
        end

        // continuous contention from reset
        reset_dut();
`ifdef RAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b0, 11'h005, 9'h1A5);
        for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b0, 11'h123, 9'h055);
`else
        for (int k = 0; k < 3; k++) begin
            push_exp(1'b0, 1'b0, 11'h005, 9'h1A5);
            push_exp(1'b1, 1'b0, 11'h123, 9'h055);
        end
`endif
        fork
            begin for (int k = 0; k < 3; k++) do_req(0, 1'b0, 11'h005, 9'h000, lat_a); end
            begin for (int k = 0; k < 3; k++) do_req(1, 1'b0, 11'h123, 9'h000, lat_b); end
        join
        repeat (4) @(negedge clk);

        // ext write vs cpu read on the same address: grant order decides the data
        push_exp(1'b0, 1'b0, 11'h7FF, 9'h1FF);
        push_exp(1'b1, 1'b1, 11'h7FF, 9'h0FF);
        push_exp(1'b0, 1'b0, 11'h7FF, 9'h0FF);
        fork
            do_req(1, 1'b1, 11'h7FF, 9'h0FF, lat_b);
            do_req(0, 1'b0, 11'h7FF, 9'h000, lat_a);
        join
        do_req(0, 1'b0, 11'h7FF, 9'h000, lat_a);
        repeat (3) @(negedge clk);

        // reset while the read is in RD_WAIT
        push_exp(1'b0, 1'b0, 11'h005, 9'h1A5);
        do_req(0, 1'b0, 11'h005, 9'h000, lat_a);
        @(negedge clk);
        chk("pre_rst_state", 32'(dbg_state), 32'(2));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_ram_en", 32'(ram_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(1'b0, 1'b1, 11'h010, 9'h011);
        push_exp(1'b1, 1'b1, 11'h020, 9'h022);
        fork
            do_req(0, 1'b1, 11'h010, 9'h011, lat_a);
            do_req(1, 1'b1, 11'h020, 9'h022, lat_b);
        join
        repeat (2) @(negedge clk);

        // ext pulses a request for one cycle while cpu holds the RAM
        push_exp(1'b0, 1'b1, 11'h030, 9'h033);
        fork
            do_req(0, 1'b1, 11'h030, 9'h033, lat_a);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!gnt[0] && n < 40);
                we1 = 1'b1; addr1 = 11'h040; wd1 = 9'h1EE; req1 = 1'b1;
                @(negedge clk);
                req1 = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        chk("pulse_no_write", 32'(mem[11'h040]), 32'd0);
        chk("cpu_write_landed", 32'(mem[11'h030]), 32'h033);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("no_pending_read", 32'(rd_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
